// File: rtl/up_dwn_cnt_param_if.sv
// Port bundle for up_dwn_cnt_param: command strobes in from the pushbutton
// logic, count and limit status out to the setting registers.
interface up_dwn_cnt_param_if #(
    parameter int WIDTH = 8
);
    // clr/ld/en are per-cycle strobes sampled on every rising clk edge;
    // there is no backpressure, so every asserted strobe is acted on.
    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic             dwn;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             at_max;
    logic             at_min;
    logic             lim_p;
    logic [15:0]      lim_cnt;

    modport master (
        output clr, ld, ld_val, en, dwn,
        input  cnt, dir, at_max, at_min, lim_p, lim_cnt
    );

    modport slave (
        input  clr, ld, ld_val, en, dwn,
        output cnt, dir, at_max, at_min, lim_p, lim_cnt
    );
endinterface

// File: rtl/up_dwn_cnt_param.sv
// Parametrised up/down counter with wrap/saturate/bounce limit modes.
// Define UDC_LIM_CNT_EN to build the saturating 16-bit limit-event counter.
module up_dwn_cnt_param #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int MODE    = 0,
    parameter int STEP    = 1
) (
    input logic              clk,
    input logic              rst_n,
    up_dwn_cnt_param_if.slave bus
);

    // Two guard bits: one for the carry of cnt+STEP, one for the sign of cnt-STEP.
    localparam int SW = WIDTH + 2;

    localparam logic signed [SW-1:0] L_MIN   = SW'(MIN_VAL);
    localparam logic signed [SW-1:0] L_MAX   = SW'(MAX_VAL);
    localparam logic signed [SW-1:0] L_STEP  = SW'(STEP);
    localparam logic signed [SW-1:0] L_ONE   = SW'(1);
    localparam logic [WIDTH-1:0]     L_MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]     L_MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0]      r_cnt;
    logic                  r_dir;
    logic                  r_lim_p;

    logic signed [SW-1:0]  w_cnt_s;
    logic signed [SW-1:0]  w_ldv_s;
    logic signed [SW-1:0]  w_cand;
    logic                  w_down;
    logic                  w_over;
    logic                  w_under;
    logic [WIDTH-1:0]      w_ld_clamp;
    logic [WIDTH-1:0]      w_step_val;
    logic                  w_step_dir;
    logic                  w_step_lim;
    logic [WIDTH-1:0]      w_cnt_nxt;
    logic                  w_dir_nxt;
    logic                  w_lim_nxt;

    assign w_cnt_s = $signed({2'b00, r_cnt});
    assign w_ldv_s = $signed({2'b00, bus.ld_val});

    // Only bounce mode steers itself; the other modes follow the dwn input.
    assign w_down  = (MODE == 2) ? r_dir : bus.dwn;
    assign w_cand  = w_down ? (w_cnt_s - L_STEP) : (w_cnt_s + L_STEP);
    assign w_over  = (w_cand > L_MAX);
    assign w_under = (w_cand < L_MIN);

    always_comb begin
        w_ld_clamp = bus.ld_val;
        if (w_ldv_s < L_MIN) begin
            w_ld_clamp = L_MIN_W;
        end else if (w_ldv_s > L_MAX) begin
            w_ld_clamp = L_MAX_W;
        end
    end

    // Result of one enabled step, including the mode's bound rule.
    always_comb begin
        w_step_val = WIDTH'(w_cand);
        w_step_dir = r_dir;
        w_step_lim = 1'b0;
        if (w_over || w_under) begin
            w_step_lim = 1'b1;
            if (MODE == 0) begin
                if (w_over) begin
                    w_step_val = WIDTH'(L_MIN + (w_cand - L_MAX - L_ONE));
                end else begin
                    w_step_val = WIDTH'(L_MAX - (L_MIN - w_cand - L_ONE));
                end
            end else begin
                w_step_val = w_over ? L_MAX_W : L_MIN_W;
                if (MODE == 2) begin
                    // Park on the bound just crossed and head back into range.
                    w_step_dir = w_over;
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_lim_nxt = 1'b0;
        if (bus.clr) begin
            w_cnt_nxt = L_MIN_W;
            w_dir_nxt = 1'b0;
        end else if (bus.ld) begin
            w_cnt_nxt = w_ld_clamp;
        end else if (bus.en) begin
            w_cnt_nxt = w_step_val;
            w_dir_nxt = w_step_dir;
            w_lim_nxt = w_step_lim;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= L_MIN_W;
            r_dir   <= 1'b0;
            r_lim_p <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_lim_p <= w_lim_nxt;
        end
    end

    assign bus.cnt    = r_cnt;
    assign bus.dir    = (MODE == 2) ? r_dir : bus.dwn;
    assign bus.at_max = (r_cnt == L_MAX_W);
    assign bus.at_min = (r_cnt == L_MIN_W);
    assign bus.lim_p  = r_lim_p;

`ifdef UDC_LIM_CNT_EN
    logic [15:0] r_lim_cnt;

    // Counts on the same edge that raises lim_p, so it tracks pulses seen so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lim_cnt <= 16'h0000;
        end else if (bus.clr) begin
            r_lim_cnt <= 16'h0000;
        end else if (w_lim_nxt && (r_lim_cnt != 16'hFFFF)) begin
            r_lim_cnt <= r_lim_cnt + 16'h0001;
        end
    end

    assign bus.lim_cnt = r_lim_cnt;
`else
    assign bus.lim_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_up_dwn_cnt_param.sv
// Drives wrap, saturate and bounce instances of up_dwn_cnt_param with shared
// stimulus and compares each against an arithmetic model of the counting rules.
module tb_up_dwn_cnt_param;

    localparam int W     = 4;
    localparam int MINV  = 2;
    localparam int MAXV  = 12;
    localparam int STEPV = 3;
    localparam int RNG   = MAXV - MINV + 1;
`ifdef UDC_LIM_CNT_EN
    localparam bit LIMCNT = 1'b1;
`else
    localparam bit LIMCNT = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    int m_cnt[3];
    int m_dir[3];
    int m_lim[3];
    int m_lcnt[3];

    up_dwn_cnt_param_if #(.WIDTH(W)) if0 ();
    up_dwn_cnt_param_if #(.WIDTH(W)) if1 ();
    up_dwn_cnt_param_if #(.WIDTH(W)) if2 ();

    up_dwn_cnt_param #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .MODE(0), .STEP(STEPV))
        u_dut_wrap (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    up_dwn_cnt_param #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .MODE(1), .STEP(STEPV))
        u_dut_sat (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    up_dwn_cnt_param #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .MODE(2), .STEP(STEPV))
        u_dut_bnc (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_cnt[m]  = MINV;
            m_dir[m]  = 0;
            m_lim[m]  = 0;
            m_lcnt[m] = 0;
        end
    endtask

    function automatic int clampv(input int v);
        if (v < MINV) return MINV;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    // One clock of the counting rules for mode m, in plain integer arithmetic.
    task automatic model_step(input int m, input bit c, input bit l, input int lv,
                              input bit e, input bit d);
        int dirv;
        int cand;
        int lim;
        lim = 0;
        if (c) begin
            m_cnt[m]  = MINV;
            m_dir[m]  = 0;
            m_lcnt[m] = 0;
        end else if (l) begin
            m_cnt[m] = clampv(lv);
        end else if (e) begin
            dirv = (m == 2) ? m_dir[m] : int'(d);
            cand = (dirv != 0) ? m_cnt[m] - STEPV : m_cnt[m] + STEPV;
            if (cand > MAXV || cand < MINV) begin
                lim = 1;
                if (m == 0) begin
                    m_cnt[m] = MINV + (((cand - MINV) % RNG) + RNG) % RNG;
                end else begin
                    m_cnt[m] = clampv(cand);
                    if (m == 2) m_dir[m] = (cand > MAXV) ? 1 : 0;
                end
            end else begin
                m_cnt[m] = cand;
            end
        end
        m_lim[m] = lim;
        if (LIMCNT && lim != 0 && m_lcnt[m] < 65535) m_lcnt[m]++;
    endtask

    task automatic check_all(input bit d);
        int cnt_o[3];
        int dir_o[3];
        int lim_o[3];
        int mx_o[3];
        int mn_o[3];
        int lc_o[3];
        cnt_o = '{int'(if0.cnt), int'(if1.cnt), int'(if2.cnt)};
        dir_o = '{int'(if0.dir), int'(if1.dir), int'(if2.dir)};
        lim_o = '{int'(if0.lim_p), int'(if1.lim_p), int'(if2.lim_p)};
        mx_o  = '{int'(if0.at_max), int'(if1.at_max), int'(if2.at_max)};
        mn_o  = '{int'(if0.at_min), int'(if1.at_min), int'(if2.at_min)};
        lc_o  = '{int'(if0.lim_cnt), int'(if1.lim_cnt), int'(if2.lim_cnt)};
        for (int m = 0; m < 3; m++) begin
            check($sformatf("m%0d_cnt", m), cnt_o[m], m_cnt[m]);
            check($sformatf("m%0d_dir", m), dir_o[m], (m == 2) ? m_dir[m] : int'(d));
            check($sformatf("m%0d_lim_p", m), lim_o[m], m_lim[m]);
            check($sformatf("m%0d_at_max", m), mx_o[m], (m_cnt[m] == MAXV) ? 1 : 0);
            check($sformatf("m%0d_at_min", m), mn_o[m], (m_cnt[m] == MINV) ? 1 : 0);
            check($sformatf("m%0d_lim_cnt", m), lc_o[m], m_lcnt[m]);
        end
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit d);
        if0.clr = c; if0.ld = l; if0.ld_val = W'(lv); if0.en = e; if0.dwn = d;
        if1.clr = c; if1.ld = l; if1.ld_val = W'(lv); if1.en = e; if1.dwn = d;
        if2.clr = c; if2.ld = l; if2.ld_val = W'(lv); if2.en = e; if2.dwn = d;
    endtask

    // Driver: apply one cycle of inputs, advance the model, check all outputs.
    task automatic step(input bit c, input bit l, input int lv, input bit e, input bit d);
        @(negedge clk);
        drive(c, l, lv, e, d);
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) model_step(m, c, l, lv, e, d);
        check_all(d);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap across both bounds.
        step(0, 1, 11, 0, 0);
        step(0, 0, 0, 1, 0);
        check("wrap_up_cnt", int'(if0.cnt), 3);
        step(0, 0, 0, 1, 1);
        check("wrap_dn_cnt", int'(if0.cnt), 11);

        // Saturate with en held against the top bound.
        step(0, 1, 10, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("sat_hold_cnt", int'(if1.cnt), 12);
        step(0, 0, 0, 1, 1);
        check("sat_dn_cnt", int'(if1.cnt), 9);

        // Priority and load clamping.
        step(1, 1, 7, 1, 0);
        check("prio_clr_cnt", int'(if0.cnt), MINV);
        step(0, 1, 15, 1, 0);
        check("ld_clamp_cnt", int'(if1.cnt), MAXV);
        step(0, 1, 0, 0, 0);
        check("ld_clamp_lo", int'(if2.cnt), MINV);

        // Repeated limit events at MAX, then clr.
        step(0, 1, 12, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        check("sat_lim_cnt", int'(if1.lim_cnt), LIMCNT ? 4 : 0);
        step(1, 0, 0, 0, 0);

        // Bounce run from MIN, then asynchronous reset mid-cycle.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        check("bnc_cnt", int'(if2.cnt), 9);
        check("bnc_dir", int'(if2.dir), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 0);
        check("post_rst_cnt", int'(if2.cnt), 5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
